// File: rtl/avr_cpu_sequencer_pkg.sv
// rtl/avr_cpu_sequencer_pkg.sv - shared ALU codes, sequencer states and opcode match masks
package avr_cpu_common;

   typedef enum logic [3:0] {
      ALU_OP_MOVE = 4'd0,
      ALU_OP_ADD  = 4'd1,
      ALU_OP_SUB  = 4'd2,
      ALU_OP_AND  = 4'd3,
      ALU_OP_OR   = 4'd4,
      ALU_OP_EOR  = 4'd5
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_DECODE  = 2'd0,
      ST_FETCH_K = 2'd1,
      ST_FLUSH   = 2'd2
   } seq_state_t;

   typedef enum logic [3:0] {
      OP_NOP, OP_ALU, OP_LDI, OP_IN, OP_OUT, OP_RJMP, OP_JMP, OP_LDS, OP_STS
   } op_class_t;

   typedef enum logic [1:0] {
      LONG_JMP = 2'd0,
      LONG_LDS = 2'd1,
      LONG_STS = 2'd2
   } long_kind_t;

   localparam logic [15:0] MASK_ALU  = 16'hFC00;
   localparam logic [15:0] MATCH_ADD = 16'h0C00;
   localparam logic [15:0] MATCH_SUB = 16'h1800;
   localparam logic [15:0] MATCH_AND = 16'h2000;
   localparam logic [15:0] MATCH_EOR = 16'h2400;
   localparam logic [15:0] MATCH_OR  = 16'h2800;
   localparam logic [15:0] MATCH_MOV = 16'h2C00;
   localparam logic [15:0] MASK_LDI  = 16'hF000;
   localparam logic [15:0] MATCH_LDI = 16'hE000;
   localparam logic [15:0] MASK_IO   = 16'hF800;
   localparam logic [15:0] MATCH_IN  = 16'hB000;
   localparam logic [15:0] MATCH_OUT = 16'hB800;
   localparam logic [15:0] MASK_RJMP = 16'hF000;
   localparam logic [15:0] MATCH_RJMP = 16'hC000;
   localparam logic [15:0] MASK_JMP  = 16'hFE0E;
   localparam logic [15:0] MATCH_JMP = 16'h940C;
   localparam logic [15:0] MASK_LDST = 16'hFE0F;
   localparam logic [15:0] MATCH_LDS = 16'h9000;
   localparam logic [15:0] MATCH_STS = 16'h9200;

   function automatic logic op_match(input logic [15:0] op, input logic [15:0] mask,
                                     input logic [15:0] pattern);
      return (op & mask) == pattern;
   endfunction

endpackage

// File: rtl/avr_cpu_decode_word.sv
// rtl/avr_cpu_decode_word.sv - combinational field extraction and classification of one opcode word
module avr_cpu_decode_word
   import avr_cpu_common::*;
(
   input  logic [15:0] i_opcode,
   output op_class_t   o_op,
   output alu_op_t     o_alu,
   output logic [4:0]  o_alu_d,
   output logic [4:0]  o_alu_r,
   output logic [4:0]  o_ldi_d,
   output logic [4:0]  o_field,
   output logic [7:0]  o_imm,
   output logic [5:0]  o_io_addr,
   output logic [5:0]  o_jmp_hi
);

   assign o_alu_d   = i_opcode[8:4];
   assign o_alu_r   = {i_opcode[9], i_opcode[3:0]};
   assign o_ldi_d   = {1'b1, i_opcode[7:4]};
   assign o_field   = i_opcode[8:4];
   assign o_imm     = {i_opcode[11:8], i_opcode[3:0]};
   assign o_io_addr = {i_opcode[10:9], i_opcode[3:0]};
   assign o_jmp_hi  = {i_opcode[8:4], i_opcode[0]};

   always_comb begin
      o_op  = OP_NOP;
      o_alu = ALU_OP_MOVE;
      if (op_match(i_opcode, MASK_ALU, MATCH_ADD)) begin
         o_op = OP_ALU; o_alu = ALU_OP_ADD;
      end else if (op_match(i_opcode, MASK_ALU, MATCH_SUB)) begin
         o_op = OP_ALU; o_alu = ALU_OP_SUB;
      end else if (op_match(i_opcode, MASK_ALU, MATCH_AND)) begin
         o_op = OP_ALU; o_alu = ALU_OP_AND;
      end else if (op_match(i_opcode, MASK_ALU, MATCH_EOR)) begin
         o_op = OP_ALU; o_alu = ALU_OP_EOR;
      end else if (op_match(i_opcode, MASK_ALU, MATCH_OR)) begin
         o_op = OP_ALU; o_alu = ALU_OP_OR;
      end else if (op_match(i_opcode, MASK_ALU, MATCH_MOV)) begin
         o_op = OP_ALU; o_alu = ALU_OP_MOVE;
      end else if (op_match(i_opcode, MASK_LDI, MATCH_LDI)) begin
         o_op = OP_LDI;
      end else if (op_match(i_opcode, MASK_IO, MATCH_IN)) begin
         o_op = OP_IN;
      end else if (op_match(i_opcode, MASK_IO, MATCH_OUT)) begin
         o_op = OP_OUT;
      end else if (op_match(i_opcode, MASK_RJMP, MATCH_RJMP)) begin
         o_op = OP_RJMP;
      end else if (op_match(i_opcode, MASK_JMP, MATCH_JMP)) begin
         o_op = OP_JMP;
      end else if (op_match(i_opcode, MASK_LDST, MATCH_LDS)) begin
         o_op = OP_LDS;
      end else if (op_match(i_opcode, MASK_LDST, MATCH_STS)) begin
         o_op = OP_STS;
      end
   end

endmodule

// File: rtl/avr_cpu_sequencer.sv
// rtl/avr_cpu_sequencer.sv - multi-cycle decode/sequencing stage: FSM, second-word latches, PC targets
module avr_cpu_sequencer
   import avr_cpu_common::*;
#(
   parameter int PC_WIDTH    = 12,
   parameter int ENABLE_LONG = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [15:0]         opcode,
   input  logic                opcode_valid,
   input  logic [PC_WIDTH-1:0] pc,
   output logic [3:0]          alu,
   output logic [4:0]          r_addr,
   output logic [4:0]          d_addr,
   output logic [7:0]          immediate,
   output logic                use_immediate,
   output logic [5:0]          io_addr,
   output logic                io_read,
   output logic                io_write,
   output logic [15:0]         mem_addr,
   output logic                mem_read,
   output logic                mem_write,
   output logic                hold,
   output logic                pc_load,
   output logic [PC_WIDTH-1:0] pc_target
);

   seq_state_t r_state, w_next_state;
   long_kind_t r_kind;
   logic [5:0] r_hi;
   logic [4:0] r_reg;

   op_class_t  w_op, w_op_eff;
   alu_op_t    w_alu, w_alu_out;
   logic [4:0] w_alu_d, w_alu_r, w_ldi_d, w_field;
   logic [5:0] w_io_addr, w_jmp_hi;
   logic [PC_WIDTH-1:0] w_rjmp_target, w_jmp_target;

   avr_cpu_decode_word u_decode (
      .i_opcode  (opcode),
      .o_op      (w_op),
      .o_alu     (w_alu),
      .o_alu_d   (w_alu_d),
      .o_alu_r   (w_alu_r),
      .o_ldi_d   (w_ldi_d),
      .o_field   (w_field),
      .o_imm     (immediate),
      .o_io_addr (w_io_addr),
      .o_jmp_hi  (w_jmp_hi)
   );

   // Without long support the two-word ops collapse to NOP, leaving FETCH_K unreachable.
   assign w_op_eff = ((ENABLE_LONG == 0) && (w_op == OP_JMP || w_op == OP_LDS || w_op == OP_STS))
                     ? OP_NOP : w_op;

   assign w_rjmp_target = pc + PC_WIDTH'(1) + PC_WIDTH'({{20{opcode[11]}}, opcode[11:0]});
   assign w_jmp_target  = PC_WIDTH'({r_hi, opcode});
   assign alu           = w_alu_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_DECODE;
      else          r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_kind <= LONG_JMP;
         r_hi   <= '0;
         r_reg  <= '0;
      end else if (r_state == ST_DECODE && opcode_valid) begin
         case (w_op_eff)
            OP_JMP: begin r_kind <= LONG_JMP; r_hi <= w_jmp_hi; end
            OP_LDS: begin r_kind <= LONG_LDS; r_reg <= w_field; end
            OP_STS: begin r_kind <= LONG_STS; r_reg <= w_field; end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_DECODE:
            if (opcode_valid) begin
               case (w_op_eff)
                  OP_RJMP:                w_next_state = ST_FLUSH;
                  OP_JMP, OP_LDS, OP_STS: w_next_state = ST_FETCH_K;
                  default:                w_next_state = ST_DECODE;
               endcase
            end
         ST_FETCH_K:
            if (opcode_valid)
               w_next_state = (r_kind == LONG_JMP) ? ST_FLUSH : ST_DECODE;
         default: w_next_state = ST_DECODE;
      endcase
   end

   always_comb begin
      w_alu_out     = ALU_OP_MOVE;
      r_addr        = '0;
      d_addr        = '0;
      use_immediate = 1'b0;
      io_addr       = '0;
      io_read       = 1'b0;
      io_write      = 1'b0;
      mem_addr      = '0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      hold          = 1'b0;
      pc_load       = 1'b0;
      pc_target     = '0;
      case (r_state)
         ST_DECODE:
            if (opcode_valid) begin
               case (w_op_eff)
                  OP_ALU: begin w_alu_out = w_alu; d_addr = w_alu_d; r_addr = w_alu_r; end
                  OP_LDI: begin d_addr = w_ldi_d; use_immediate = 1'b1; end
                  OP_IN: begin
                     r_addr = w_field; d_addr = w_field; io_addr = w_io_addr; io_read = 1'b1;
                  end
                  OP_OUT: begin
                     r_addr = w_field; d_addr = w_field; io_addr = w_io_addr; io_write = 1'b1;
                  end
                  OP_RJMP: begin pc_load = 1'b1; pc_target = w_rjmp_target; hold = 1'b1; end
                  OP_JMP:  hold = 1'b1;
                  default: ;
               endcase
            end
         ST_FETCH_K:
            if (!opcode_valid) begin
               hold = 1'b1;
            end else begin
               case (r_kind)
                  LONG_JMP: begin pc_load = 1'b1; pc_target = w_jmp_target; hold = 1'b1; end
                  LONG_LDS: begin mem_addr = opcode; mem_read = 1'b1; d_addr = r_reg; end
                  default:  begin mem_addr = opcode; mem_write = 1'b1; r_addr = r_reg; end
               endcase
            end
         default: ;
      endcase
      if (!reset_n) begin
         io_read = 1'b0; io_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
         pc_load = 1'b0; hold = 1'b0;
      end
   end

endmodule

// File: tb/tb_avr_cpu_sequencer.sv
// tb/tb_avr_cpu_sequencer.sv - directed self-checking bench for avr_cpu_sequencer
module tb_avr_cpu_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] opcode;
   logic        opcode_valid;
   logic [11:0] pc;

   logic [3:0]  alu, s_alu;
   logic [4:0]  r_addr, d_addr, s_r_addr, s_d_addr;
   logic [7:0]  immediate, s_immediate;
   logic        use_immediate, s_use_immediate;
   logic [5:0]  io_addr, s_io_addr;
   logic        io_read, io_write, s_io_read, s_io_write;
   logic [15:0] mem_addr, s_mem_addr;
   logic        mem_read, mem_write, s_mem_read, s_mem_write;
   logic        hold, pc_load, s_hold, s_pc_load;
   logic [11:0] pc_target, s_pc_target;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   avr_cpu_sequencer #(.PC_WIDTH(12), .ENABLE_LONG(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .opcode_valid(opcode_valid), .pc(pc),
      .alu(alu), .r_addr(r_addr), .d_addr(d_addr), .immediate(immediate),
      .use_immediate(use_immediate), .io_addr(io_addr), .io_read(io_read),
      .io_write(io_write), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_write(mem_write), .hold(hold), .pc_load(pc_load), .pc_target(pc_target)
   );

   avr_cpu_sequencer #(.PC_WIDTH(12), .ENABLE_LONG(0)) u_dut_short (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .opcode_valid(opcode_valid), .pc(pc),
      .alu(s_alu), .r_addr(s_r_addr), .d_addr(s_d_addr), .immediate(s_immediate),
      .use_immediate(s_use_immediate), .io_addr(s_io_addr), .io_read(s_io_read),
      .io_write(s_io_write), .mem_addr(s_mem_addr), .mem_read(s_mem_read),
      .mem_write(s_mem_write), .hold(s_hold), .pc_load(s_pc_load), .pc_target(s_pc_target)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [15:0] op, input logic v, input logic [11:0] p);
      @(posedge clk);
      #1;
      opcode       = op;
      opcode_valid = v;
      pc           = p;
      #1;
   endtask

   initial begin
      reset_n      = 1'b0;
      opcode       = 16'hB71F;
      opcode_valid = 1'b1;
      pc           = 12'h000;
      #3;
      check_eq("rst_io_read", 32'(io_read), 32'd0);
      check_eq("rst_hold",    32'(hold),    32'd0);
      check_eq("rst_pc_load", 32'(pc_load), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // LDI r16,0xA5
      drive(16'hEA05, 1'b1, 12'h000);
      check_eq("ldi_d",    32'(d_addr),        32'd16);
      check_eq("ldi_imm",  32'(immediate),     32'hA5);
      check_eq("ldi_use",  32'(use_immediate), 32'd1);
      check_eq("ldi_hold", 32'(hold),          32'd0);
      check_eq("ldi_alu",  32'(alu),           32'd0);

      // IN r17,0x3F ; OUT 0x05,r2
      drive(16'hB71F, 1'b1, 12'h001);
      check_eq("in_rd",   32'(io_read), 32'd1);
      check_eq("in_addr", 32'(io_addr), 32'h3F);
      check_eq("in_r",    32'(r_addr),  32'd17);
      check_eq("in_d",    32'(d_addr),  32'd17);
      drive(16'hB825, 1'b1, 12'h002);
      check_eq("out_wr",   32'(io_write), 32'd1);
      check_eq("out_rd",   32'(io_read),  32'd0);
      check_eq("out_addr", 32'(io_addr),  32'h05);
      check_eq("out_d",    32'(d_addr),   32'd2);

      // SUB r20,r31 ; EOR r1,r2
      drive(16'h1B4F, 1'b1, 12'h003);
      check_eq("sub_alu", 32'(alu),    32'd2);
      check_eq("sub_d",   32'(d_addr), 32'd20);
      check_eq("sub_r",   32'(r_addr), 32'd31);
      drive(16'h2412, 1'b1, 12'h004);
      check_eq("eor_alu", 32'(alu),    32'd5);
      check_eq("eor_d",   32'(d_addr), 32'd1);
      check_eq("eor_r",   32'(r_addr), 32'd2);

      // RJMP .-1 at 0x010, flush, then ADD r0,r1
      drive(16'hCFFF, 1'b1, 12'h010);
      check_eq("rjmp_load", 32'(pc_load),   32'd1);
      check_eq("rjmp_tgt",  32'(pc_target), 32'h010);
      check_eq("rjmp_hold", 32'(hold),      32'd1);
      drive(16'h0C01, 1'b1, 12'h011);
      check_eq("rjmp_fl_load", 32'(pc_load), 32'd0);
      check_eq("rjmp_fl_hold", 32'(hold),    32'd0);
      check_eq("rjmp_fl_alu",  32'(alu),     32'd0);
      check_eq("rjmp_fl_r",    32'(r_addr),  32'd0);
      drive(16'h0C01, 1'b1, 12'h010);
      check_eq("add_alu", 32'(alu),    32'd1);
      check_eq("add_r",   32'(r_addr), 32'd1);

      // RJMP wrap-around: 0xFFF+1+0 and 0x005+1-2048
      drive(16'hC000, 1'b1, 12'hFFF);
      check_eq("rjmp_wrap_hi", 32'(pc_target), 32'h000);
      drive(16'h0000, 1'b0, 12'h000);
      drive(16'hC800, 1'b1, 12'h005);
      check_eq("rjmp_wrap_lo", 32'(pc_target), 32'h806);
      drive(16'h0000, 1'b0, 12'h000);

      // JMP 0x0123
      drive(16'h940C, 1'b1, 12'h020);
      check_eq("jmp1_hold", 32'(hold),    32'd1);
      check_eq("jmp1_load", 32'(pc_load), 32'd0);
      drive(16'h0123, 1'b1, 12'h021);
      check_eq("jmp2_load", 32'(pc_load),   32'd1);
      check_eq("jmp2_tgt",  32'(pc_target), 32'h123);
      check_eq("jmp2_hold", 32'(hold),      32'd1);
      drive(16'hEA05, 1'b1, 12'h123);
      check_eq("jmp3_load", 32'(pc_load),       32'd0);
      check_eq("jmp3_hold", 32'(hold),          32'd0);
      check_eq("jmp3_use",  32'(use_immediate), 32'd0);

      // JMP with high bits set and a stall; target truncated to 12 bits
      drive(16'h95FD, 1'b1, 12'h030);
      drive(16'h0000, 1'b0, 12'h031);
      check_eq("jmphi_stall_hold", 32'(hold),    32'd1);
      check_eq("jmphi_stall_load", 32'(pc_load), 32'd0);
      drive(16'h4567, 1'b1, 12'h031);
      check_eq("jmphi_tgt", 32'(pc_target), 32'h567);
      drive(16'h0000, 1'b0, 12'h000);

      // LDS r5,0x0100 with two invalid cycles
      drive(16'h9050, 1'b1, 12'h040);
      check_eq("lds1_hold", 32'(hold),     32'd0);
      check_eq("lds1_rd",   32'(mem_read), 32'd0);
      for (int i = 0; i < 2; i++) begin
         drive(16'h0000, 1'b0, 12'h041);
         check_eq("lds_stall_rd",   32'(mem_read), 32'd0);
         check_eq("lds_stall_hold", 32'(hold),     32'd1);
      end
      drive(16'h0100, 1'b1, 12'h041);
      check_eq("lds_rd",   32'(mem_read), 32'd1);
      check_eq("lds_addr", 32'(mem_addr), 32'h0100);
      check_eq("lds_d",    32'(d_addr),   32'd5);
      check_eq("lds_hold", 32'(hold),     32'd0);
      drive(16'hEA05, 1'b1, 12'h042);
      check_eq("lds_after_rd", 32'(mem_read), 32'd0);
      check_eq("lds_after_d",  32'(d_addr),   32'd16);

      // STS 0x0200,r3
      drive(16'h9230, 1'b1, 12'h050);
      check_eq("sts1_wr", 32'(mem_write), 32'd0);
      drive(16'h0200, 1'b1, 12'h051);
      check_eq("sts_wr",   32'(mem_write), 32'd1);
      check_eq("sts_addr", 32'(mem_addr),  32'h0200);
      check_eq("sts_r",    32'(r_addr),    32'd3);

      // Reset during FETCH_K of STS abandons it
      drive(16'h9230, 1'b1, 12'h060);
      drive(16'h0100, 1'b0, 12'h061);
      check_eq("stsr_hold", 32'(hold), 32'd1);
      reset_n      = 1'b0;
      opcode_valid = 1'b1;
      #1;
      check_eq("stsr_rst_wr",   32'(mem_write), 32'd0);
      check_eq("stsr_rst_hold", 32'(hold),      32'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      #1;
      check_eq("stsr_rel_wr", 32'(mem_write), 32'd0);
      drive(16'hEA05, 1'b1, 12'h000);
      check_eq("stsr_ldi_d",   32'(d_addr),        32'd16);
      check_eq("stsr_ldi_use", 32'(use_immediate), 32'd1);
      check_eq("stsr_ldi_wr",  32'(mem_write),     32'd0);

      // ENABLE_LONG=0: JMP opcode is a single-cycle NOP
      drive(16'h940C, 1'b1, 12'h070);
      check_eq("short_jmp_hold", 32'(s_hold),    32'd0);
      check_eq("short_jmp_load", 32'(s_pc_load), 32'd0);
      check_eq("short_jmp_alu",  32'(s_alu),     32'd0);
      drive(16'hEA05, 1'b1, 12'h071);
      check_eq("short_next_d",   32'(s_d_addr),        32'd16);
      check_eq("short_next_use", 32'(s_use_immediate), 32'd1);
      check_eq("short_next_imm", 32'(s_immediate),     32'hA5);
      drive(16'h9050, 1'b1, 12'h072);
      drive(16'h0100, 1'b1, 12'h073);
      check_eq("short_lds_rd", 32'(s_mem_read), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/avr_cpu_sequencer.md
# avr_cpu_sequencer

Multi-cycle instruction decode/sequencing stage for the AVR core. It replaces the single-cycle combinational decoder and takes one 16-bit opcode word per cycle from fetch. It decodes register-ALU ops, LDI, IN/OUT, RJMP, and optionally the two-word JMP/LDS/STS. It drives the register file, ALU, IO and data-memory strobes, and the PC load/hold controls.

## Interface
- PC_WIDTH, 12: program-counter width in words; all jump targets are taken modulo 2^PC_WIDTH.
- ENABLE_LONG, 1: 1 enables the two-word instructions JMP/LDS/STS; 0 decodes them as single-cycle NOP.
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  16  current instruction word from fetch.
- opcode_valid  in  1  opcode is meaningful this cycle.
- pc  in  PC_WIDTH  word address of the current opcode.
- alu  out  4  ALU operation code from the shared package.
- r_addr, d_addr  out  5 each  source and destination register.
- immediate  out  8  {opcode[11:8],opcode[3:0]}.
- use_immediate  out  1  ALU B operand = immediate.
- io_addr  out  6  {opcode[10:9],opcode[3:0]}.
- io_read, io_write  out  1 each  IN / OUT strobes.
- mem_addr  out  16  data address for LDS/STS.
- mem_read, mem_write  out  1 each  LDS / STS strobes.
- hold  out  1  fetch must keep the PC (not advance) this cycle.
- pc_load  out  1  load pc_target into PC.
- pc_target  out  PC_WIDTH  jump destination.

## Operation
- Encodings:
  - ADD 0000_11rd; SUB 0001_10rd; AND 0010_00rd; EOR 0010_01rd; OR 0010_10rd; MOV 0010_11rd.
  - For these ALU ops, d = opcode[8:4] and r = {opcode[9],opcode[3:0]}.
  - LDI 1110: d = {1,opcode[7:4]}, with use_immediate.
  - IN 1011_0 / OUT 1011_1: r_addr = d_addr = opcode[8:4].
  - RJMP 1100.
  - JMP 1001_010k_kkkk_110k.
  - LDS 1001_000d_dddd_0000; STS 1001_001r_rrrr_0000.
  - Anything else is NOP.
- NOP defaults: alu=ALU_OP_MOVE, addresses 0, all strobes, hold, and pc_load 0.
- States: DECODE, FETCH_K (waiting for the second word), FLUSH (discard the prefetched word).
- DECODE:
  - opcode_valid=0 gives a NOP and the state stays DECODE.
  - Single-cycle ops decode combinationally; the state stays DECODE.
  - RJMP: pc_load=1, pc_target = pc + 1 + sext(opcode[11:0]), hold=1, next state FLUSH.
  - JMP: latch hi = {opcode[8:4],opcode[0]}, hold=1, next state FETCH_K.
  - LDS/STS: latch the register field and kind, hold=0 (so the PC advances to the K word), next state FETCH_K.
- FETCH_K:
  - opcode_valid=0: all strobes 0, hold=1, stay in FETCH_K.
  - JMP: pc_load=1, pc_target = {hi,opcode}[PC_WIDTH-1:0], hold=1, next state FLUSH.
  - LDS: mem_addr=opcode, mem_read=1, d_addr=latched, next state DECODE.
  - STS: mem_addr=opcode, mem_write=1, r_addr=latched, next state DECODE.
- FLUSH: outputs NOP regardless of opcode, hold=0, next state DECODE.
- Reset:
  - Asynchronous; state goes to DECODE and the latched fields clear to 0.
  - While reset_n=0 every strobe (io_*, mem_*, pc_load, hold) is forced to 0.
  - Reset in the middle of any multi-cycle instruction abandons it with no strobe issued.

## Timing
- Outputs are combinational from the state and latched fields plus the opcode; the state updates on the clk rising edge.
- Cycle counts: ALU/LDI/IN/OUT 1; RJMP 2; LDS/STS 2 (+ invalid-word stall cycles); JMP 3 (+ stalls).
- pc_load is a single-cycle pulse.
- pc_target arithmetic is PC_WIDTH bits, unsigned, wrapping with no overflow indication.
- ENABLE_LONG=0: the FETCH_K state is unreachable and the state logic may be pruned.

## Structure
- The shared avr_cpu_common package holds:
  - ALU_OP_* codes: MOVE, ADD, SUB, AND, OR, EOR.
  - State encodings.
  - Opcode match masks.
- One sub-module, avr_cpu_decode_word: purely combinational single-word field extraction and op classification.
- The sequencer adds the FSM, the latches, and the PC arithmetic.

## Test plan
- LDI r16,0xA5 (0xEA05), valid: same cycle d_addr=16, immediate=0xA5, use_immediate=1, hold=0; state stays DECODE.
- RJMP .-1 (0xCFFF) at pc=0x010: cycle 1 pc_load=1, target=0x010, hold=1; cycle 2 NOP with opcode 0x0C01 applied; cycle 3 decodes normally.
- JMP 0x0123 (0x940C, 0x0123): cycle 1 hold=1 with no pc_load; cycle 2 pc_load=1, target=0x123; cycle 3 NOP.
- LDS r5,0x0100 (0x9050, 0x0100) with opcode_valid=0 for two cycles before the K word: mem_read stays 0 with hold=1 while invalid, then one mem_read cycle with mem_addr=0x0100, d_addr=5.
- reset_n pulsed low during FETCH_K of STS: no mem_write at any time; after release, 0xEA05 decodes as LDI.
- ENABLE_LONG=0, opcode 0x940C: NOP, hold=0; the next word decodes as a new instruction.
